// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Operands and funct3 are captured when the E-stage instruction is accepted.
// Products come from a 32-cycle shift-add loop and quotients from a 32-cycle
// restoring-division loop. BusyE stalls the front of the pipeline meanwhile,
// and a one-cycle DoneE pulse presents the held ResultE to the E|M register.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FlushE,
    input  logic             StartE,
    input  logic [2:0]       Funct3E,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    output logic             BusyE,
    output logic             DoneE,
    output logic [WIDTH-1:0] ResultE
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;
    logic   accept;

    // Operation context captured at accept.
    logic [2:0]         func_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic [CW-1:0]      count_q;
    // Upper half: running product high / partial remainder.
    // Lower half: multiplier bits still to consume / dividend shifting into quotient.
    logic [2*WIDTH-1:0] acc_q;
    // Multiplicand magnitude for multiplies, divisor magnitude for divides.
    logic [WIDTH-1:0]   opnd_q;
    // Sign-corrected result waiting in DONE for the output register.
    logic [WIDTH-1:0]   final_q;

    // Accept-time decode of the incoming instruction.
    logic             op_is_div;
    logic             op_signed_a;
    logic             op_signed_b;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             div_zero;
    logic             div_ovf;
    logic             special;
    logic [WIDTH-1:0] special_res;

    // Decode the incoming op: sign handling, magnitudes and the divide corner cases.
    always_comb begin
        op_is_div   = Funct3E[2];
        op_signed_a = Funct3E inside {3'b001, 3'b010, 3'b100, 3'b110};
        op_signed_b = Funct3E inside {3'b001, 3'b100, 3'b110};
        neg_a       = op_signed_a && SrcAE[WIDTH-1];
        neg_b       = op_signed_b && SrcBE[WIDTH-1];
        mag_a       = neg_a ? -SrcAE : SrcAE;
        mag_b       = neg_b ? -SrcBE : SrcBE;
        div_zero    = op_is_div && (SrcBE == '0);
        // Only DIV and REM (funct3[0] = 0) can overflow.
        div_ovf     = op_is_div && !Funct3E[0] && (SrcAE == MIN_NEG) && (SrcBE == ALL_ONES);
        special     = div_zero || div_ovf;
        // funct3[1] separates remainder ops from quotient ops.
        if (div_zero) begin
            special_res = Funct3E[1] ? SrcAE : ALL_ONES;
        end else begin
            special_res = Funct3E[1] ? '0 : MIN_NEG;
        end
    end

    // One iteration step of either algorithm.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] acc_next;

    // Shift-add multiply step and restoring divide step; funct3[2] picks which is used.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
        if (func_q[2]) begin
            if (div_trial[WIDTH+1]) begin
                // Trial went negative: restore, quotient bit is 0.
                acc_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_next = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign fix and result selection on the final iteration's value.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   calc_res;

    // Apply operand signs to the magnitude result and pick the field funct3 asks for.
    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_next : acc_next;
        quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        rem_fix  = sign_a_q ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
        case (func_q)
            3'b000:         calc_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:         calc_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: calc_res = quo_fix;
            default:        calc_res = rem_fix;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, regardless of statement order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, accept and stall logic; FlushE overrides any transition.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        next_state = state;
        BusyE      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                BusyE = StartE;
                if (StartE && !FlushE) begin
                    accept     = 1'b1;
                    next_state = special ? DONE : CALC;
                end
            end
            CALC: begin
                BusyE = 1'b1;
                if (count_q == LAST_ITER) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (FlushE) begin
            next_state = IDLE;
        end
    end

    // Datapath: capture at accept, iterate in CALC, publish the result from DONE.
    always_ff @(posedge clk) begin
        // NOTE: all datapath registers are plain flops (no memory arrays), so the
        // whole context is cleared on reset, including ResultE.
        if (reset) begin
            func_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            final_q  <= '0;
            DoneE    <= 1'b0;
            ResultE  <= '0;
        end else begin
            DoneE <= 1'b0;
            if (accept) begin
                func_q   <= Funct3E;
                sign_a_q <= neg_a;
                sign_b_q <= neg_b;
                count_q  <= '0;
                if (op_is_div) begin
                    acc_q  <= {{WIDTH{1'b0}}, mag_a};
                    opnd_q <= mag_b;
                end else begin
                    acc_q  <= {{WIDTH{1'b0}}, mag_b};
                    opnd_q <= mag_a;
                end
                if (special) begin
                    final_q <= special_res;
                end
            end else if (state == CALC && !FlushE) begin
                acc_q   <= acc_next;
                count_q <= count_q + CW'(1);
                if (count_q == LAST_ITER) begin
                    final_q <= calc_res;
                end
            end else if (state == DONE && !FlushE) begin
                DoneE   <= 1'b1;
                ResultE <= final_q;
            end
        end
    end

endmodule
